// File: rtl/dpu_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dpu_mac_sequencer
// Purpose  : Streams k_len operand words into the 2x2 MAC array, chains the
//            accumulators, then applies bias/LeakyReLU/requantize/int8 saturate.
// Options  : DPU_SEQ_ROUND_EN selects round-half-up requantize (default: truncate)
// Revision : 1.0 - initial release
// ============================================================================
module dpu_mac_sequencer #(
  parameter int K_MAX = 256,
  parameter int KW    = $clog2(K_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [KW-1:0] k_len,
  input  logic [31:0]   bias0,
  input  logic [31:0]   bias1,
  input  logic [4:0]    shift,
  output logic          busy,
  output logic          done,
  output logic          op_rd_en,
  output logic [KW-1:0] op_addr,
  input  logic [31:0]   op_w,
  input  logic [15:0]   op_a,
  output logic          mac_valid,
  output logic [31:0]   mac_w,
  output logic [15:0]   mac_a,
  output logic [63:0]   mac_acc_in,
  input  logic [63:0]   mac_acc_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [15:0]   res_data
);

  localparam logic [KW-1:0] C_KMAX = KW'(K_MAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_POST  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [KW-1:0] r_cnt, r_klen;
  logic          r_drain, r_first, r_mac_valid, r_done;
  logic [63:0]   r_bias;
  logic [4:0]    r_shift;
  logic [15:0]   r_res;
  logic          w_last;
  logic [7:0]    w_out [2];

  function automatic logic [7:0] f_post(input logic signed [31:0] acc,
                                        input logic signed [31:0] bias,
                                        input logic [4:0]         sh);
    logic signed [33:0] y, l, q;
    y = 34'(acc) + 34'(bias);
    l = (y > 34'sd0) ? y : (y >>> 3);
`ifdef DPU_SEQ_ROUND_EN
    if (sh != 5'd0) q = (l + (34'sd1 <<< (sh - 5'd1))) >>> sh;
    else            q = l;
`else
    q = l >>> sh;
`endif
    if (q > 34'sd127)       return 8'h7F;
    else if (q < -34'sd128) return 8'h80;
    else                    return q[7:0];
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_col
    assign w_out[gi] = f_post(mac_acc_out[32*gi +: 32], r_bias[32*gi +: 32], r_shift);
  end

  assign w_last = (r_cnt == r_klen - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != S_IDLE);
    op_rd_en    = (r_state == S_RUN);
    op_addr     = (r_state == S_RUN) ? r_cnt : '0;
    res_valid   = (r_state == S_OUT);
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start && (k_len != '0)) w_state_nxt = S_RUN;
        S_RUN:   if (w_last) w_state_nxt = S_DRAIN;
        S_DRAIN: if (r_drain) w_state_nxt = S_POST;
        S_POST:  w_state_nxt = S_OUT;
        S_OUT:   if (res_ready) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_klen      <= '0;
      r_drain     <= 1'b0;
      r_first     <= 1'b0;
      r_mac_valid <= 1'b0;
      r_done      <= 1'b0;
      r_bias      <= '0;
      r_shift     <= '0;
      r_res       <= '0;
    end else begin
      r_done      <= 1'b0;
      r_mac_valid <= op_rd_en && !abort;
      r_drain     <= (r_state == S_DRAIN) ? ~r_drain : 1'b0;
      if (r_mac_valid) r_first <= 1'b0;
      if ((r_state == S_IDLE) && start && !abort) begin
        if (k_len == '0) begin
          r_done <= 1'b1;
        end else begin
          r_klen  <= (k_len > C_KMAX) ? C_KMAX : k_len;
          r_bias  <= {bias1, bias0};
          r_shift <= shift;
          r_cnt   <= '0;
          r_first <= 1'b1;
        end
      end
      if ((r_state == S_RUN) && !abort) r_cnt <= r_cnt + 1'b1;
      if (r_state == S_POST) r_res <= {w_out[1], w_out[0]};
      if ((r_state == S_OUT) && res_ready && !abort) r_done <= 1'b1;
    end
  end

  // Operand buffer output is already registered; gate it with the step strobe.
  assign mac_valid  = r_mac_valid;
  assign mac_w      = r_mac_valid ? op_w : '0;
  assign mac_a      = r_mac_valid ? op_a : '0;
  assign mac_acc_in = (r_mac_valid && !r_first) ? mac_acc_out : '0;
  assign done       = r_done;
  assign res_data   = r_res;

endmodule
`default_nettype wire
